// File: rtl/icache_refill_ctrl_pkg.sv
// Shared constants, state encoding and address helper for the instruction
// cache refill controller.
package icache_refill_ctrl_pkg;

   localparam int WORD_W          = 16;
   localparam int LINE_WORDS_DFLT = 4;
   localparam int WORD_BYTES_FIX  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } refill_state_e;

   // Clear the offset-within-line bits; line_bytes is a power of two.
   function automatic logic [WORD_W-1:0] line_base(input logic [WORD_W-1:0] addr,
                                                   input int line_bytes);
      logic [WORD_W-1:0] mask;
      mask = WORD_W'(line_bytes - 1);
      return addr & ~mask;
   endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch, memory and fill-port signals of the refill controller; the
// controller sits on the slave side, fetch stage / memory / cache on master.
interface icache_refill_ctrl_if;
   import icache_refill_ctrl_pkg::*;

   logic              inp_fetchValid;
   logic [WORD_W-1:0] inp_fetchAddr;
   logic              inp_hit;
   logic              out_stall;
   logic              out_memReq;
   logic [WORD_W-1:0] out_memAddr;
   logic              inp_memReady;
   logic [WORD_W-1:0] inp_memData;
   logic              out_fillWe;
   logic [WORD_W-1:0] out_fillAddr;
   logic [WORD_W-1:0] out_fillData;
   logic              out_fillDone;
   logic [WORD_W-1:0] out_missCount;

   modport slave (
      input  inp_fetchValid, inp_fetchAddr, inp_hit, inp_memReady, inp_memData,
      output out_stall, out_memReq, out_memAddr, out_fillWe, out_fillAddr,
             out_fillData, out_fillDone, out_missCount
   );

   modport master (
      output inp_fetchValid, inp_fetchAddr, inp_hit, inp_memReady, inp_memData,
      input  out_stall, out_memReq, out_memAddr, out_fillWe, out_fillAddr,
             out_fillData, out_fillDone, out_missCount
   );

endinterface

// File: rtl/icache_refill_ctrl_sat_counter16.sv
// 16-bit counter that sticks at all-ones instead of wrapping.
module sat_counter16
   import icache_refill_ctrl_pkg::*;
(
   input  logic              inp_clk,
   input  logic              inp_rst,
   input  logic              inp_inc,
   output logic [WORD_W-1:0] out_count
);

   logic [WORD_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inp_inc && (count_q != {WORD_W{1'b1}}))
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge inp_clk) begin
      if (inp_rst) count_q <= '0;
      else         count_q <= count_d;
   end

   assign out_count = count_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Blocking instruction-cache line refill: on a miss, stalls fetch and reads
// the whole line in ascending word order, then pulses fillDone for the tag.
module icache_refill_ctrl
   import icache_refill_ctrl_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DFLT,
   parameter int WORD_BYTES = WORD_BYTES_FIX
) (
   input logic                 inp_clk,
   input logic                 inp_rst,
   icache_refill_ctrl_if.slave bus
);

   localparam int CNT_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam int LINE_BYTES = LINE_WORDS * WORD_BYTES;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_FILL = FILL;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] base_q, base_d;
   logic [WORD_W-1:0] word_addr;
   logic              miss, start, last;

   assign miss  = bus.inp_fetchValid & ~bus.inp_hit;
   assign start = (state_q == S_IDLE) & miss;
   assign last  = (cnt_q == CNT_W'(LINE_WORDS - 1));

   // Base is line-aligned, so the offset add never carries out of the line.
   assign word_addr = base_q + (WORD_W'(cnt_q) * WORD_W'(WORD_BYTES));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      case (state_q)
         S_IDLE: begin
            if (miss) begin
               state_d = S_FILL;
               cnt_d   = '0;
               base_d  = line_base(bus.inp_fetchAddr, LINE_BYTES);
            end
         end
         S_FILL: begin
            if (bus.inp_memReady) begin
               cnt_d = cnt_q + 1'b1;
               if (last) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge inp_clk) begin
      if (inp_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
      end
   end

   // Outputs are forced quiet while reset is held, whatever the state.
   always_comb begin
      bus.out_stall    = 1'b0;
      bus.out_memReq   = 1'b0;
      bus.out_memAddr  = '0;
      bus.out_fillWe   = 1'b0;
      bus.out_fillAddr = '0;
      bus.out_fillData = '0;
      bus.out_fillDone = 1'b0;
      if (!inp_rst) begin
         case (state_q)
            S_IDLE: bus.out_stall = miss;
            S_FILL: begin
               bus.out_stall   = 1'b1;
               bus.out_memReq  = 1'b1;
               bus.out_memAddr = word_addr;
               if (bus.inp_memReady) begin
                  bus.out_fillWe   = 1'b1;
                  bus.out_fillAddr = word_addr;
                  bus.out_fillData = bus.inp_memData;
               end
            end
            S_DONE: begin
               bus.out_stall    = 1'b1;
               bus.out_fillDone = 1'b1;
               bus.out_fillAddr = base_q;
            end
            default: ;
         endcase
      end
   end

   sat_counter16 u_miss_cnt (
      .inp_clk   (inp_clk),
      .inp_rst   (inp_rst),
      .inp_inc   (start),
      .out_count (bus.out_missCount)
   );

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 Parameter LINE_WORDS, default 4, words per cache line (power of two, 2..16) SHALL be supported.
REQ-002 Parameter WORD_BYTES, default 2, byte stride between consecutive 16-bit instruction words, SHALL be fixed at 2.
REQ-003 inp_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 inp_rst  in  1  reset, synchronous and active-high.
REQ-005 inp_fetchValid  in  1  fetch stage is presenting an address this cycle.
REQ-006 inp_fetchAddr  in  16  byte address of current instruction fetch.
REQ-007 inp_hit  in  1  instruction cache hit for inp_fetchAddr.
REQ-008 out_stall  out  1  freeze PC and fetch/decode register.
REQ-009 out_memReq  out  1  read request to instruction memory.
REQ-010 out_memAddr  out  16  byte address of requested word.
REQ-011 inp_memReady  in  1  inp_memData valid for current request.
REQ-012 inp_memData  in  16  returned instruction word.
REQ-013 out_fillWe  out  1  write one word into cache data array.
REQ-014 out_fillAddr  out  16  byte address of word being written.
REQ-015 out_fillData  out  16  word being written.
REQ-016 out_fillDone  out  1  one-cycle pulse: write tag and set valid for line at out_fillAddr.
REQ-017 out_missCount  out  16  saturating count of refills started.

Function
REQ-018 States SHALL be IDLE, FILL, DONE.
REQ-019 IDLE: out_stall SHALL equal inp_fetchValid & ~inp_hit (combinational, same cycle as miss).
REQ-020 IDLE -> FILL when inp_fetchValid & ~inp_hit; line base = inp_fetchAddr with low log2(LINE_WORDS*2) bits cleared SHALL be latched; word counter cleared; out_missCount incremented unless 0xFFFF.
REQ-021 FILL: out_stall=1, out_memReq=1, out_memAddr = base + 2*count, held stable until inp_memReady.
REQ-022 FILL with inp_memReady: out_fillWe=1, out_fillAddr=out_memAddr, out_fillData=inp_memData in that same cycle; count increments.
REQ-023 FILL with inp_memReady and count==LINE_WORDS-1 -> DONE; otherwise remain in FILL.
REQ-024 DONE: out_stall=1, out_fillDone=1, out_fillAddr=base, out_memReq=0; next state IDLE unconditionally.
REQ-025 Refill order SHALL be strictly ascending from base; no critical-word-first, no early restart.
REQ-026 Address arithmetic SHALL be 16-bit; line at 0xFFF8 fills 0xFFF8..0xFFFE with no carry past the line.
REQ-027 inp_memReady while out_memReq=0 SHALL be ignored.
REQ-028 inp_fetchAddr/inp_hit changes during FILL or DONE SHALL be ignored; refill always completes.
REQ-029 Outputs out_fillWe, out_fillDone, out_memReq SHALL be 0 in IDLE.
REQ-030 Best-case miss penalty (memReady every FILL cycle): LINE_WORDS+1 stall cycles after the detect cycle, i.e., 6 total with default.
REQ-031 out_missCount SHALL saturate at 0xFFFF, never wrap.

Reset
REQ-032 inp_rst high at an edge SHALL force IDLE, count=0, base=0, out_missCount=0 regardless of state.
REQ-033 Reset mid-FILL SHALL drop out_memReq the following cycle and SHALL NOT produce out_fillDone; partial line stays invalid.
REQ-034 During reset out_stall, out_memReq, out_fillWe, out_fillDone SHALL be 0; out_memAddr, out_fillAddr, out_fillData SHALL be 0.

Structure
REQ-035 Shared package SHALL hold state enum (IDLE/FILL/DONE), LINE_WORDS default, WORD_BYTES, 16-bit word width constant.
REQ-036 Saturating miss counter SHALL be a sub-module sat_counter16 (inp_clk, inp_rst, inp_inc, out_count).
REQ-037 Word counter, base register and FSM SHALL live in icache_refill_ctrl.

Verification
REQ-038 Hit path: fetchValid=1, hit=1 for 10 cycles -> stall=0, memReq=0, missCount=0 throughout.
REQ-039 Miss at 0x0106, memReady every cycle -> memAddr 0x0100,0x0102,0x0104,0x0106 on consecutive cycles, 4 fillWe pulses with matching data, fillDone one cycle with fillAddr=0x0100, stall high 6 cycles, missCount=1.
REQ-040 Miss at 0x0020, memReady asserted every 3rd cycle -> memAddr held stable between readies, exactly 4 fillWe, fillDone once.
REQ-041 Miss at 0xFFFA -> fills 0xFFF8..0xFFFE, no access to 0x0000.
REQ-042 Reset asserted after second word of a refill -> next cycle IDLE, memReq=0, no fillDone, missCount=0; subsequent miss refills from word 0.
REQ-043 Preload missCount near 0xFFFF via repeated misses (or forced) -> stays 0xFFFF on further miss.
